key_event_arbiter: RTL
======================

KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: event FIFO depth; SHALL be a power of two, 2..16.
REQ-002 Parameter CW, default 8: width of drop counter.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 btn_pulse  input  4  one-cycle debounced key pulses, one per key; bit0 jump, bit1 duck, bit2 start, bit3 pause.
REQ-006 evt_valid  output  1  FIFO head holds an event.
REQ-007 evt_code  output  2  key index of head event.
REQ-008 evt_ready  input  1  consumer accepts head event this cycle.
REQ-009 pend  output  4  per-key pending flags, registered.
REQ-010 fifo_full  output  1  FIFO occupancy equals DEPTH.
REQ-011 drop_cnt  output  CW  count of merged (lost) key events, saturating.

Function
REQ-012 pend[i] SHALL be set at the clock edge where btn_pulse[i]=1.
REQ-013 pend[i] SHALL clear at the edge where key i is granted, unless btn_pulse[i]=1 in that same cycle, in which case it SHALL stay 1.
REQ-014 A pulse on key i while pend[i]=1 and key i not granted that cycle SHALL be merged: drop_cnt += 1 per merged key that cycle, saturating at 2^CW-1, no wrap.
REQ-015 At most one grant per cycle; grant SHALL be combinational from the registered pend, the rotate pointer and FIFO space.
REQ-016 Grant SHALL be allowed when occupancy < DEPTH, or when occupancy = DEPTH and a pop (evt_valid && evt_ready) occurs that cycle.
REQ-017 Arbitration SHALL be round-robin: search pend starting at (last_grant+1) mod 4; last_grant updates only on a grant.
REQ-018 A grant SHALL push the granted key index into the FIFO tail at that edge.
REQ-019 Latency: pulse in cycle t with empty FIFO and no competing keys -> evt_valid=1 with the code in cycle t+2; no empty-FIFO bypass.
REQ-020 Pop SHALL occur when evt_valid && evt_ready; evt_code SHALL be held stable while evt_valid && !evt_ready.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged, at any occupancy including DEPTH; pop at empty SHALL have no effect.
REQ-022 Pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-023 evt_valid SHALL equal (occupancy != 0); fifo_full SHALL equal (occupancy == DEPTH); both registered-derived, glitch-free.
REQ-024 Pending keys that cannot be granted (FIFO full, no pop) SHALL remain pending, not dropped.

Reset
REQ-025 While rst=1 at an edge: pend=0, occupancy=0, FIFO pointers=0, drop_cnt=0, last_grant=3 (key 0 first priority), evt_valid=0, evt_code=0, fifo_full=0.
REQ-026 btn_pulse and evt_ready SHALL be ignored in any cycle where rst=1; reset mid-operation SHALL discard all queued and pending events.
REQ-027 No initial-value reliance; all state SHALL be defined by rst.

Verification
REQ-028 btn_pulse=4'b0001 at cycle t, evt_ready=1 -> evt_valid=1, evt_code=0 in cycle t+2 only; pend=0 from t+2.
REQ-029 btn_pulse=4'b1111 at t, evt_ready=1 -> evt_code 0,1,2,3 in cycles t+2..t+5, evt_valid continuous, then 0.
REQ-030 evt_ready=0, pulses keys 0,1,2,3 on cycles t..t+3, key 0 at t+4 and t+6 -> fifo_full=1 from t+5, pend=4'b0001, drop_cnt=1; heads stay code 0.
REQ-031 From REQ-030 state, evt_ready=1 one cycle -> code 0 popped and key 0 pushed same edge, fifo_full stays 1, pend=0.
REQ-032 btn_pulse=4'b0011 every cycle, evt_ready=1 -> granted sequence 0,1,0,1..., drop_cnt increments by 1 per cycle after the first.
REQ-033 FIFO holding 3 events, pend=4'b0100, rst=1 one cycle -> all outputs zero next cycle; then btn_pulse=4'b0100 -> evt_code=2 two cycles later.

Source files
------------

// File: rtl/key_event_arbiter.sv
// Four-key event arbiter: per-key pending flags, round-robin grant into a small
// event FIFO, and a saturating counter of key presses merged while still pending.
module key_event_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    btn_pulse,
    output logic          evt_valid,
    output logic [1:0]    evt_code,
    input  logic          evt_ready,
    output logic [3:0]    pend,
    output logic          fifo_full,
    output logic [CW-1:0] drop_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [1:0]    last_grant;

    logic          pop;
    logic          can_grant;
    logic          grant;
    logic [1:0]    grant_idx;
    logic [1:0]    cand;
    logic [3:0]    grant_mask;
    logic [3:0]    merged;
    logic [2:0]    merge_cnt;
    logic [CW:0]   drop_sum;
    logic [CW-1:0] drop_next;

    assign evt_valid = (occ != '0);
    assign fifo_full = (occ == (AW + 1)'(DEPTH));
    assign evt_code  = evt_valid ? fifo_mem[rd_ptr] : '0;
    assign pop       = evt_valid & evt_ready;
    // A full FIFO can still accept a grant when its head leaves this cycle.
    assign can_grant = !fifo_full || pop;

    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!grant && pend[cand]) begin
                grant     = 1'b1;
                grant_idx = cand;
            end
        end
        if (!can_grant) begin
            grant = 1'b0;
        end
    end

    assign grant_mask = grant ? (4'b0001 << grant_idx) : 4'b0000;
    assign merged     = btn_pulse & pend & ~grant_mask;

    always_comb begin
        merge_cnt = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            merge_cnt = merge_cnt + 3'(merged[i]);
        end
        drop_sum  = {1'b0, drop_cnt} + (CW + 1)'(merge_cnt);
        drop_next = drop_sum[CW] ? '1 : drop_sum[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            occ        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_cnt   <= '0;
            last_grant <= 2'd3;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            pend     <= btn_pulse | (pend & ~grant_mask);
            drop_cnt <= drop_next;
            if (grant) begin
                fifo_mem[wr_ptr] <= grant_idx;
                wr_ptr           <= wr_ptr + AW'(1);
                last_grant       <= grant_idx;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({grant, pop})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule
